// File: rtl/tlb_controller.sv
// Arbiter and sequencer for the shared single-port TLB: serves fetch, data and CP0 TLB ops,
// registers translation results and exception codes, and maintains the Random register.
module tlb_controller #(
    parameter int unsigned ENTRY_ADDR_WIDTH = 3
) (
    input  logic                        clk,
    input  logic                        res,
    input  logic                        i_req,
    input  logic                        d_req,
    input  logic                        op_req,
    input  logic [31:0]                 i_vaddr,
    input  logic [31:0]                 d_vaddr,
    input  logic                        d_write,
    input  logic [1:0]                  op_code,
    input  logic [31:0]                 cp0_entry_hi,
    input  logic [ENTRY_ADDR_WIDTH-1:0] cp0_index,
    input  logic [ENTRY_ADDR_WIDTH-1:0] wired,
    input  logic                        wired_we,
    output logic                        i_ack,
    output logic                        d_ack,
    output logic                        op_ack,
    output logic [31:0]                 i_paddr,
    output logic [31:0]                 d_paddr,
    output logic [1:0]                  i_exc,
    output logic [1:0]                  d_exc,
    output logic [31:0]                 probe_index,
    output logic [ENTRY_ADDR_WIDTH-1:0] random,
    output logic [31:0]                 tlb_vaddr,
    output logic [31:0]                 tlb_index,
    output logic                        tlb_re,
    output logic                        tlb_we,
    input  logic [31:0]                 tlb_paddr,
    input  logic                        tlb_found,
    input  logic                        tlb_bitV,
    input  logic                        tlb_bitD,
    input  logic [31:0]                 tlb_matched_index
);

    localparam logic [ENTRY_ADDR_WIDTH-1:0] RandMax = '1;
    localparam logic [1:0] OpTlbp  = 2'd0;
    localparam logic [1:0] OpTlbr  = 2'd1;
    localparam logic [1:0] OpTlbwi = 2'd2;
    localparam logic [1:0] OpTlbwr = 2'd3;

    typedef enum logic [1:0] {StIdle, StXlate, StOp, StResp} state_e;
    typedef enum logic [1:0] {SelI, SelD, SelOp} sel_e;

    state_e                      state_q, state_d;
    sel_e                        sel_q, sel_d;
    logic                        last_d_q, last_d_d;
    logic [1:0]                  op_q, op_d;
    logic                        write_q, write_d;
    logic [ENTRY_ADDR_WIDTH-1:0] random_q, random_d;
    logic [31:0]                 tlb_vaddr_q, tlb_vaddr_d;
    logic [ENTRY_ADDR_WIDTH-1:0] tlb_index_q, tlb_index_d;
    logic                        tlb_re_q, tlb_re_d, tlb_we_q, tlb_we_d;
    logic                        i_ack_q, i_ack_d, d_ack_q, d_ack_d, op_ack_q, op_ack_d;
    logic [31:0]                 i_paddr_q, i_paddr_d, d_paddr_q, d_paddr_d;
    logic [1:0]                  i_exc_q, i_exc_d, d_exc_q, d_exc_d;
    logic [31:0]                 probe_q, probe_d;
    logic                        grant_d;
    logic [1:0]                  xl_exc;
    logic [31:0]                 xl_paddr;

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        last_d_d    = last_d_q;
        op_d        = op_q;
        write_d     = write_q;
        tlb_vaddr_d = tlb_vaddr_q;
        tlb_index_d = tlb_index_q;
        tlb_re_d    = tlb_re_q;
        tlb_we_d    = 1'b0;
        i_ack_d     = 1'b0;
        d_ack_d     = 1'b0;
        op_ack_d    = 1'b0;
        i_paddr_d   = i_paddr_q;
        d_paddr_d   = d_paddr_q;
        i_exc_d     = i_exc_q;
        d_exc_d     = d_exc_q;
        probe_d     = probe_q;

        if (wired_we || random_q == wired || wired >= RandMax) begin
            random_d = RandMax;
        end else begin
            random_d = random_q - ENTRY_ADDR_WIDTH'(1);
        end

        // d wins a tie unless it was the last one served
        grant_d = d_req && (!i_req || !last_d_q);

        if (!tlb_found) begin
            xl_exc = 2'd1;
        end else if (!tlb_bitV) begin
            xl_exc = 2'd2;
        end else if (!tlb_bitD && sel_q == SelD && write_q) begin
            xl_exc = 2'd3;
        end else begin
            xl_exc = 2'd0;
        end
        xl_paddr = (xl_exc == 2'd0) ? tlb_paddr : 32'd0;

        unique case (state_q)
            StIdle: begin
                tlb_re_d    = 1'b0;
                tlb_index_d = '0;
                if (op_req) begin
                    sel_d   = SelOp;
                    op_d    = op_code;
                    state_d = StOp;
                    unique case (op_code)
                        OpTlbp:  tlb_vaddr_d = {cp0_entry_hi[31:13], 13'b0};
                        OpTlbr:  begin tlb_re_d = 1'b1; tlb_index_d = cp0_index; end
                        OpTlbwi: begin tlb_we_d = 1'b1; tlb_index_d = cp0_index; end
                        OpTlbwr: begin tlb_we_d = 1'b1; tlb_index_d = random_q; end
                        default: ;
                    endcase
                end else if (grant_d) begin
                    sel_d       = SelD;
                    tlb_vaddr_d = d_vaddr;
                    write_d     = d_write;
                    last_d_d    = 1'b1;
                    state_d     = StXlate;
                end else if (i_req) begin
                    sel_d       = SelI;
                    tlb_vaddr_d = i_vaddr;
                    write_d     = 1'b0;
                    last_d_d    = 1'b0;
                    state_d     = StXlate;
                end
            end
            StXlate: begin
                if (sel_q == SelD) begin
                    d_exc_d   = xl_exc;
                    d_paddr_d = xl_paddr;
                    d_ack_d   = 1'b1;
                end else begin
                    i_exc_d   = xl_exc;
                    i_paddr_d = xl_paddr;
                    i_ack_d   = 1'b1;
                end
                state_d = StResp;
            end
            StOp: begin
                if (op_q == OpTlbp) begin
                    probe_d = tlb_found ?
                        {{(32-ENTRY_ADDR_WIDTH){1'b0}}, tlb_matched_index[ENTRY_ADDR_WIDTH-1:0]} :
                        32'h8000_0000;
                end
                // TLBR keeps index/re through the ack cycle so CP0 can sample the entry
                if (op_q != OpTlbr) begin
                    tlb_index_d = '0;
                end
                op_ack_d = 1'b1;
                state_d  = StResp;
            end
            StResp: begin
                tlb_re_d    = 1'b0;
                tlb_index_d = '0;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q     <= StIdle;
            sel_q       <= SelI;
            last_d_q    <= 1'b0;
            op_q        <= 2'd0;
            write_q     <= 1'b0;
            random_q    <= RandMax;
            tlb_vaddr_q <= 32'd0;
            tlb_index_q <= '0;
            tlb_re_q    <= 1'b0;
            tlb_we_q    <= 1'b0;
            i_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            op_ack_q    <= 1'b0;
            i_paddr_q   <= 32'd0;
            d_paddr_q   <= 32'd0;
            i_exc_q     <= 2'd0;
            d_exc_q     <= 2'd0;
            probe_q     <= 32'd0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            last_d_q    <= last_d_d;
            op_q        <= op_d;
            write_q     <= write_d;
            random_q    <= random_d;
            tlb_vaddr_q <= tlb_vaddr_d;
            tlb_index_q <= tlb_index_d;
            tlb_re_q    <= tlb_re_d;
            tlb_we_q    <= tlb_we_d;
            i_ack_q     <= i_ack_d;
            d_ack_q     <= d_ack_d;
            op_ack_q    <= op_ack_d;
            i_paddr_q   <= i_paddr_d;
            d_paddr_q   <= d_paddr_d;
            i_exc_q     <= i_exc_d;
            d_exc_q     <= d_exc_d;
            probe_q     <= probe_d;
        end
    end

    assign i_ack       = i_ack_q;
    assign d_ack       = d_ack_q;
    assign op_ack      = op_ack_q;
    assign i_paddr     = i_paddr_q;
    assign d_paddr     = d_paddr_q;
    assign i_exc       = i_exc_q;
    assign d_exc       = d_exc_q;
    assign probe_index = probe_q;
    assign random      = random_q;
    assign tlb_vaddr   = tlb_vaddr_q;
    assign tlb_index   = {{(32-ENTRY_ADDR_WIDTH){1'b0}}, tlb_index_q};
    assign tlb_re      = tlb_re_q;
    assign tlb_we      = tlb_we_q;

    logic unused_bits;
    assign unused_bits = ^{cp0_entry_hi[12:0], tlb_matched_index[31:ENTRY_ADDR_WIDTH]};

endmodule
